// File: rtl/fpu_dsq_pkg.sv
// Shared encodings and default iteration counts for the div/sqrt scheduler.
// BUSY_SQRT only exists when FPU_DSQ_SQRT_EN is defined.
package fpu_dsq_pkg;

  localparam int DIV_CYCLES_DEF  = 24;
  localparam int SQRT_CYCLES_DEF = 26;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUSY_DIV  = 2'd1,
`ifdef FPU_DSQ_SQRT_EN
    BUSY_SQRT = 2'd2,
`endif
    DONE      = 2'd3
  } state_e;

  typedef enum logic {
    OP_DIV  = 1'b0,
    OP_SQRT = 1'b1
  } op_e;

endpackage

// File: rtl/fpu_dsq_sched_if.sv
// Request/result bundle between the FP pipeline (master) and the
// div/sqrt scheduler (slave).
interface fpu_dsq_sched_if;
  logic       div_req;
  logic       sqrt_req;
  logic [4:0] req_fd;
  logic [4:0] chk_fs;
  logic [4:0] chk_ft;
  logic       chk_en;
  logic       flush;
  logic       res_ack;
  logic       unit_start;
  logic       unit_op;
  logic [4:0] cnt_div;
  logic [4:0] cnt_sqrt;
  logic       accept;
  logic       busy;
  logic       stl_ds;
  logic       res_valid;
  logic       res_op;
  logic [4:0] res_fd;

  modport master (
    output div_req, sqrt_req, req_fd,
    output chk_fs, chk_ft, chk_en,
    output flush, res_ack,
    input  unit_start, unit_op,
    input  cnt_div, cnt_sqrt,
    input  accept, busy, stl_ds,
    input  res_valid, res_op, res_fd
  );

  modport slave (
    input  div_req, sqrt_req, req_fd,
    input  chk_fs, chk_ft, chk_en,
    input  flush, res_ack,
    output unit_start, unit_op,
    output cnt_div, cnt_sqrt,
    output accept, busy, stl_ds,
    output res_valid, res_op, res_fd
  );
endinterface

// File: rtl/fpu_dsq_cnt.sv
// 5-bit loadable down-counter with clear and zero flag.
module fpu_dsq_cnt (
  input  logic       clk,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic       en_i,
  input  logic       clr_i,
  input  logic [4:0] load_val_i,
  output logic [4:0] cnt_o,
  output logic       zero_o
);

  logic [4:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (load_i)
      cnt_d = load_val_i;
    else if (en_i && cnt_q != '0)
      cnt_d = cnt_q - 5'd1;
  end

  always_ff @(posedge clk) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/fpu_dsq_sched.sv
// Issue scheduler for the shared iterative div/sqrt unit.
// Sqrt support is compiled in only with FPU_DSQ_SQRT_EN.
module fpu_dsq_sched
  import fpu_dsq_pkg::*;
#(
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int SQRT_CYCLES = SQRT_CYCLES_DEF
) (
  input logic            clk,
  input logic            clrn,
  fpu_dsq_sched_if.slave bus
);

  state_e     state_q, state_d;
  op_e        op_q, op_d;
  logic [4:0] fd_q, fd_d;
  logic [4:0] cnt;
  logic       cnt_zero, cnt_load, cnt_en, cnt_clr;
  logic       sq, run_div, run_sqrt, running, busy, done;
  logic       take, take_sqrt, hit;

`ifdef FPU_DSQ_SQRT_EN
  assign sq       = bus.sqrt_req;
  assign run_sqrt = (state_q == BUSY_SQRT);
`else
  logic unused_sqrt_req;
  assign unused_sqrt_req = bus.sqrt_req;
  assign sq       = 1'b0;
  assign run_sqrt = 1'b0;
`endif

  assign run_div = (state_q == BUSY_DIV);
  assign running = run_div | run_sqrt;
  assign done    = (state_q == DONE);
  assign busy    = (state_q != IDLE);

  assign take = !clrn && !bus.flush
             && (bus.div_req || sq)
             && (!busy || (done && bus.res_ack));
  // div wins a same-cycle collision
  assign take_sqrt = take && !bus.div_req;

  assign hit = bus.chk_en && busy
            && (bus.chk_fs == fd_q || bus.chk_ft == fd_q);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    fd_d     = fd_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_clr  = 1'b0;
    if (bus.flush) begin
      state_d = IDLE;
      cnt_clr = 1'b1;
    end else if (take) begin
`ifdef FPU_DSQ_SQRT_EN
      state_d = take_sqrt ? BUSY_SQRT : BUSY_DIV;
`else
      state_d = BUSY_DIV;
`endif
      op_d     = take_sqrt ? OP_SQRT : OP_DIV;
      fd_d     = bus.req_fd;
      cnt_load = 1'b1;
    end else begin
      unique case (state_q)
        BUSY_DIV: begin
          if (cnt_zero) state_d = DONE;
          else          cnt_en  = 1'b1;
        end
`ifdef FPU_DSQ_SQRT_EN
        BUSY_SQRT: begin
          if (cnt_zero) state_d = DONE;
          else          cnt_en  = 1'b1;
        end
`endif
        DONE: if (bus.res_ack) state_d = IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clrn) begin
      state_q <= IDLE;
      op_q    <= OP_DIV;
      fd_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      fd_q    <= fd_d;
    end
  end

  fpu_dsq_cnt u_cnt (
    .clk        (clk),
    .rst_i      (clrn),
    .load_i     (cnt_load),
    .en_i       (cnt_en),
    .clr_i      (cnt_clr),
    .load_val_i (take_sqrt ? 5'(SQRT_CYCLES - 1)
                           : 5'(DIV_CYCLES - 1)),
    .cnt_o      (cnt),
    .zero_o     (cnt_zero)
  );

  assign bus.accept     = take;
  assign bus.unit_start = take;
  assign bus.unit_op    = take ? take_sqrt : run_sqrt;
  assign bus.cnt_div    = run_div  ? cnt : 5'd0;
  assign bus.cnt_sqrt   = run_sqrt ? cnt : 5'd0;
  assign bus.busy       = busy;
  assign bus.stl_ds     = !clrn
    && (((bus.div_req || sq) && !take)
        || (sq && bus.div_req) || hit);
  assign bus.res_valid  = done;
  assign bus.res_op     = done && (op_q == OP_SQRT);
  assign bus.res_fd     = done ? fd_q : 5'd0;

  logic unused_running;
  assign unused_running = running;

endmodule

// File: tb/tb_fpu_dsq_sched.sv
// Random + directed bench for fpu_dsq_sched against a cycle-count model.
module tb_fpu_dsq_sched;

`ifdef FPU_DSQ_SQRT_EN
  localparam bit SQ_EN = 1'b1;
`else
  localparam bit SQ_EN = 1'b0;
`endif
  localparam int ND = 24;
  localparam int NS = 26;

  logic clk = 1'b0;
  logic clrn;
  fpu_dsq_sched_if bus ();

  fpu_dsq_sched dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  // model: an op is active from its accept until ack/flush/reset;
  // k counts cycles since the accepting cycle
  bit         m_act = 1'b0;
  int         m_acc = 0;
  bit         m_op  = 1'b0;
  logic [4:0] m_fd  = '0;
  int         cyc   = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d",
               tag, cyc, obs, exp);
    end
  endtask

  task automatic tick(input bit dr, input bit sr,
                      input logic [4:0] fd,
                      input bit ce,
                      input logic [4:0] fs,
                      input logic [4:0] ft,
                      input bit fl, input bit ack,
                      input bit rst);
    int  k, n;
    bit  run, dn, wd, ws, ok, acc, aop, stl;
    int  e_cd, e_cs;
    @(negedge clk);
    bus.div_req  = dr;
    bus.sqrt_req = sr;
    bus.req_fd   = fd;
    bus.chk_en   = ce;
    bus.chk_fs   = fs;
    bus.chk_ft   = ft;
    bus.flush    = fl;
    bus.res_ack  = ack;
    clrn         = rst;
    #1;
    k   = cyc - m_acc;
    n   = m_op ? NS : ND;
    run = m_act && (k <= n);
    dn  = m_act && (k > n);
    wd  = dr;
    ws  = SQ_EN && sr;
    ok  = !rst && !fl && (!m_act || (dn && ack));
    acc = ok && (wd || ws);
    aop = !wd;
    stl = !rst && ((wd && !acc)
                   || (ws && !(acc && aop))
                   || (ce && m_act
                       && (fs == m_fd || ft == m_fd)));
    e_cd = (run && !m_op) ? n - k : 0;
    e_cs = (run &&  m_op) ? n - k : 0;
    chk("accept",     32'(bus.accept),     32'(acc));
    chk("unit_start", 32'(bus.unit_start), 32'(acc));
    chk("unit_op",    32'(bus.unit_op),
        32'(acc ? aop : (run && m_op)));
    chk("cnt_div",    32'(bus.cnt_div),    32'(e_cd));
    chk("cnt_sqrt",   32'(bus.cnt_sqrt),   32'(e_cs));
    chk("busy",       32'(bus.busy),       32'(m_act));
    chk("stl_ds",     32'(bus.stl_ds),     32'(stl));
    chk("res_valid",  32'(bus.res_valid),  32'(dn));
    chk("res_op",     32'(bus.res_op),     32'(dn && m_op));
    chk("res_fd",     32'(bus.res_fd),
        32'(dn ? m_fd : 5'd0));
    @(posedge clk);
    if (rst || fl)
      m_act = 1'b0;
    else if (acc) begin
      m_act = 1'b1;
      m_acc = cyc;
      m_op  = aop;
      m_fd  = fd;
    end else if (dn && ack)
      m_act = 1'b0;
    cyc++;
  endtask

  task automatic idle(input int n, input bit ack);
    for (int i = 0; i < n; i++)
      tick(0, 0, 5'd0, 0, 5'd0, 5'd0, 0, ack, 0);
  endtask

  initial begin
    bus.div_req  = 1'b0;
    bus.sqrt_req = 1'b0;
    bus.req_fd   = '0;
    bus.chk_en   = 1'b0;
    bus.chk_fs   = '0;
    bus.chk_ft   = '0;
    bus.flush    = 1'b0;
    bus.res_ack  = 1'b0;
    clrn         = 1'b1;
    @(posedge clk);
    // requests during reset are dropped
    tick(1, 1, 5'd3, 1, 5'd0, 5'd0, 0, 1, 1);
    tick(1, 0, 5'd3, 0, 5'd0, 5'd0, 0, 0, 1);

    // plain divide, result held 3 cycles without ack
    tick(1, 0, 5'd5, 0, 5'd0, 5'd0, 0, 0, 0);
    idle(24, 0);
    idle(3, 0);
    idle(1, 1);
    idle(2, 0);

    // collision: div wins, then sqrt issued on ack
    tick(1, 1, 5'd6, 0, 5'd0, 5'd0, 0, 0, 0);
    idle(25, 0);
    tick(0, 1, 5'd9, 0, 5'd0, 5'd0, 0, 1, 0);
    idle(13, 0);
    // reset mid-sqrt (cnt_sqrt=12 when built with sqrt)
    tick(0, 0, 5'd0, 0, 5'd0, 5'd0, 0, 0, 1);
    idle(2, 0);

    // RAW hazard on the latched destination
    tick(1, 0, 5'd7, 0, 5'd0, 5'd0, 0, 0, 0);
    tick(0, 0, 5'd0, 1, 5'd1, 5'd7, 0, 0, 0);
    tick(0, 0, 5'd0, 1, 5'd1, 5'd8, 0, 0, 0);
    tick(0, 0, 5'd0, 1, 5'd7, 5'd2, 0, 0, 0);
    // flush at cnt_div=10 with a competing request
    idle(10, 0);
    tick(1, 0, 5'd4, 0, 5'd0, 5'd0, 1, 0, 0);
    idle(3, 0);
    // sqrt alone from idle
    tick(0, 1, 5'd2, 0, 5'd0, 5'd0, 0, 0, 0);
    idle(30, 1);

    for (int i = 0; i < 4000; i++)
      tick($urandom_range(0, 5) == 0,
           $urandom_range(0, 5) == 0,
           5'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)),
           5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)),
           $urandom_range(0, 79) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 299) == 0);

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
